// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: steps the pc block, issues one imem request at a
// time, hands fetched words to decode and squashes responses from a stale path.
//
// state | meaning
// BOOT  | post-reset idle, counting BOOT_CYCLES before the first fetch
// REQ   | imem_req asserted at i_address, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid (dropped if discard is set)
// VALID | instr/instr_pc presented to decode, waiting for instr_ready
module fetch_ctrl #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             IF,
  output logic [1:0]       pc_cmd,
  output logic [AW-1:0]    pc_v,
  input  logic [AW-1:0]    i_address,
  output logic             imem_req,
  output logic [AW-1:0]    imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [DW-1:0]    imem_rdata,
  output logic             instr_valid,
  output logic [DW-1:0]    instr,
  output logic [AW-1:0]    instr_pc,
  input  logic             instr_ready,
  input  logic             redirect_valid,
  input  logic             redirect_abs,
  input  logic [AW-1:0]    redirect_target,
  output logic [CNT_W-1:0] perf_fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t     state_q;
  logic [3:0] boot_cnt_q;
  logic       discard_q;
  logic       redir;
  logic       hs;

  // Redirects only count once the core is out of BOOT; a handshake needs VALID.
  assign redir = redirect_valid && (state_q != S_BOOT);
  assign hs    = (state_q == S_VALID) && instr_ready;

  // The address bus mirrors the pc only while a request is on the bus.
  assign imem_addr = imem_req ? i_address : '0;

  // pc block control: a redirect wins over a sequential PC+4 step.
  always_comb begin
    IF     = 1'b0;
    pc_cmd = 2'b01;
    pc_v   = '0;
    if (redir) begin
      IF     = 1'b1;
      pc_cmd = {1'b1, redirect_abs};
      pc_v   = redirect_target;
    end else if (hs) begin
      IF     = 1'b1;
      pc_cmd = 2'b00;
    end
  end

  // Fetch sequencing with registered request/valid outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_BOOT;
      boot_cnt_q     <= '0;
      discard_q      <= 1'b0;
      imem_req       <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      perf_fetch_cnt <= '0;
    end else begin
      case (state_q)
        S_BOOT: begin
          if (boot_cnt_q == BOOT_LAST) begin
            state_q  <= S_REQ;
            imem_req <= 1'b1;
          end else begin
            boot_cnt_q <= boot_cnt_q + 4'd1;
          end
        end
        S_REQ: begin
          // Without a grant the request simply re-issues at the updated pc.
          if (imem_gnt) begin
            instr_pc  <= i_address;
            imem_req  <= 1'b0;
            discard_q <= redir;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            discard_q <= 1'b0;
            if (discard_q || redir) begin
              imem_req <= 1'b1;
              state_q  <= S_REQ;
            end else begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state_q     <= S_VALID;
            end
          end else if (redir) begin
            discard_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (redir) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state_q     <= S_REQ;
          end else if (instr_ready) begin
            instr_valid    <= 1'b0;
            imem_req       <= 1'b1;
            perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            state_q        <= S_REQ;
          end
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: pc block model, single-outstanding imem model, an
// event-level reference model checked every cycle, and directed scenarios.
module tb_fetch_ctrl;

  localparam int BOOT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IF;
  logic [1:0]  pc_cmd;
  logic [31:0] pc_v;
  logic [31:0] i_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic        redirect_abs;
  logic [31:0] redirect_target;
  logic [15:0] perf_fetch_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  fetch_ctrl #(.AW(32), .DW(32), .BOOT_CYCLES(BOOT), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .IF(IF), .pc_cmd(pc_cmd), .pc_v(pc_v),
    .i_address(i_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_abs(redirect_abs), .redirect_target(redirect_target),
    .perf_fetch_cnt(perf_fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // pc block model
  logic [31:0] pc_q;
  assign i_address = pc_q;
  always @(posedge clk) begin
    if (!reset_n) pc_q <= 32'h0;
    else if (IF) begin
      case (pc_cmd)
        2'b00:   pc_q <= pc_q + 32'd4;
        2'b10:   pc_q <= pc_q + pc_v;
        2'b11:   pc_q <= pc_v;
        default: pc_q <= pc_q;
      endcase
    end
  end

  // cycles since the last reset edge
  int rel = 0;
  always @(posedge clk) begin
    if (!reset_n) rel <= 0;
    else if (rel < 100000) rel <= rel + 1;
  end

  // instruction memory: grants after gnt_delay cycles of request, answers
  // rv_delay cycles after the grant; it is not reset with the DUT
  int          gnt_delay = 0;
  int          rv_delay  = 1;
  int          req_cnt   = 0;
  int          rv_cnt    = 0;
  bit          pending   = 1'b0;
  logic [31:0] p_addr;
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (pending) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(p_addr);
          pending     = 1'b0;
        end
      end else if (imem_req) begin
        if (req_cnt >= gnt_delay) begin
          imem_gnt = 1'b1;
          p_addr   = imem_addr;
          pending  = 1'b1;
          rv_cnt   = rv_delay;
          req_cnt  = 0;
        end else begin
          req_cnt++;
        end
      end
    end
  end

  // reference model: what must be presented, requested and steered each cycle
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc    = '0;
  bit          m_out   = 1'b0;
  logic [31:0] m_oaddr = '0;
  bit          m_stale = 1'b0;
  logic [15:0] m_cnt   = '0;

  // compare every cycle at the falling edge, then advance the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit boot, rd, hs, e_req;
      boot  = (rel < BOOT);
      rd    = redirect_valid && !boot;
      hs    = m_valid && instr_ready;
      e_req = !boot && !m_valid && !m_out;
      chk("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, i_address);
      chk("instr_valid", instr_valid, m_valid);
      if (m_valid) begin
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_pc);
      end
      chk("IF", IF, rd || hs);
      chk("pc_cmd", pc_cmd, rd ? {1'b1, redirect_abs} : (hs ? 2'b00 : 2'b01));
      chk("pc_v", pc_v, rd ? redirect_target : 32'h0);
      chk("perf_fetch_cnt", perf_fetch_cnt, m_cnt);
      if (!reset_n) begin
        m_valid = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_cnt = '0;
      end else if (!boot) begin
        if (m_valid && (rd || instr_ready)) begin
          m_valid = 1'b0;
          if (!rd) m_cnt = m_cnt + 16'd1;
        end
        if (e_req && imem_gnt) begin
          m_out = 1'b1; m_oaddr = i_address; m_stale = rd;
        end else if (m_out) begin
          if (imem_rvalid) begin
            m_out = 1'b0;
            if (!m_stale && !rd) begin
              m_valid = 1'b1; m_instr = mem_word(m_oaddr); m_pc = m_oaddr;
            end
          end else if (rd) begin
            m_stale = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_valid(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid) begin ok = 1'b1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_gnt(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_gnt) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    int first_req, first_val, nhs;
    logic [31:0] pcs [3];
    logic [31:0] held;
    bit ok;

    reset_n = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_abs = 1'b0; redirect_target = 32'h0;

    // T1: boot latency and first presentation
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    first_req = 0; first_val = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (imem_req && first_req == 0) first_req = c;
      if (instr_valid) begin first_val = c; break; end
    end
    chk("t1_first_req_cycle", first_req, 3);
    chk("t1_first_valid_cycle", first_val, 5);
    chk("t1_instr_pc", instr_pc, 32'h0);
    chk("t1_instr", instr, 32'hA5C3_0F00);

    // T2: back-to-back sequential fetch with ready held
    @(posedge clk); #1 instr_ready = 1'b1;
    nhs = 0;
    for (int i = 0; i < 40 && nhs < 3; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin pcs[nhs] = instr_pc; nhs++; end
    end
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk);
    chk("t2_handshakes", nhs, 3);
    chk("t2_pc0", pcs[0], 32'h0);
    chk("t2_pc1", pcs[1], 32'h4);
    chk("t2_pc2", pcs[2], 32'h8);
    chk("t2_perf_cnt", perf_fetch_cnt, 32'd3);

    // T3: decode back-pressure holds the word, then sequential fetch resumes
    wait_valid("t3_wait_valid");
    chk("t3_instr_pc", instr_pc, 32'hC);
    held = instr;
    gnt_delay = 2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3_instr_stable", instr, held);
      chk("t3_valid_held", instr_valid, 1'b1);
      chk("t3_no_if", IF, 1'b0);
      chk("t3_no_req", imem_req, 1'b0);
    end
    @(posedge clk); #1 instr_ready = 1'b1;
    @(negedge clk);
    chk("t3_hs_if", IF, 1'b1);
    chk("t3_hs_cmd", pc_cmd, 2'b00);
    @(posedge clk); #1 instr_ready = 1'b0;
    wait_valid("t3_wait_next");
    chk("t3_next_pc", instr_pc, 32'h10);

    // T4: absolute redirect while the fetch is in flight
    @(posedge clk); #1 gnt_delay = 0; rv_delay = 3; instr_ready = 1'b1;
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk);
    wait_gnt("t4_wait_gnt");
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_abs = 1'b1; redirect_target = 32'h100;
    @(negedge clk);
    chk("t4_if", IF, 1'b1);
    chk("t4_cmd", pc_cmd, 2'b11);
    chk("t4_pc_v", pc_v, 32'h100);
    @(posedge clk); #1 redirect_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_stale_hidden", instr_valid, 1'b0);
      if (imem_req) begin ok = 1'b1; break; end
    end
    chk("t4_req_seen", 32'(ok), 32'd1);
    chk("t4_next_addr", imem_addr, 32'h100);
    wait_valid("t4_wait_valid");
    chk("t4_instr_pc", instr_pc, 32'h100);
    chk("t4_instr", instr, 32'hA5C3_0E00);

    // T5: relative redirect coincident with a handshake at 0x20
    @(posedge clk); #1 rv_delay = 1; redirect_valid = 1'b1; redirect_abs = 1'b1; redirect_target = 32'h20;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_valid("t5_wait_valid");
    chk("t5_instr_pc", instr_pc, 32'h20);
    chk("t5_cnt_before", perf_fetch_cnt, 32'd5);
    @(posedge clk); #1 rv_delay = 3; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_abs = 1'b0; redirect_target = 32'h8;
    @(negedge clk);
    chk("t5_if", IF, 1'b1);
    chk("t5_cmd", pc_cmd, 2'b10);
    chk("t5_pc_v", pc_v, 32'h8);
    @(posedge clk); #1 instr_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_cnt_after", perf_fetch_cnt, 32'd5);
    chk("t5_valid_dropped", instr_valid, 1'b0);
    chk("t5_req", imem_req, 1'b1);
    chk("t5_next_addr", imem_addr, 32'h28);

    // T6: reset while waiting; the late response lands during BOOT
    wait_gnt("t6_wait_gnt");
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c < BOOT; c++) begin
      @(negedge clk);
      chk("t6_boot_no_req", imem_req, 1'b0);
      chk("t6_boot_no_valid", instr_valid, 1'b0);
      chk("t6_cnt_cleared", perf_fetch_cnt, 32'd0);
    end
    @(negedge clk);
    chk("t6_req_after_boot", imem_req, 1'b1);
    chk("t6_addr_after_boot", imem_addr, 32'h0);
    wait_valid("t6_wait_valid");
    chk("t6_instr_pc", instr_pc, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
